// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions: default flit width, flit-type encodings and
// the position of the 2-bit type field at the top of every flit.
package noc_flit_pkg;

    // Default flit width; must match the input-buffer FIFO data width.
    localparam int FLIT_W_DEF = 40;

    // Width of the flit-type field.
    localparam int FT_W = 2;

    // Type field bit positions, expressed as distances below the flit width:
    // the field occupies flit[FLIT_W-FT_MSB_OFS : FLIT_W-FT_LSB_OFS].
    localparam int FT_MSB_OFS = 1;
    localparam int FT_LSB_OFS = 2;

    // Flit-type encodings.
    typedef enum logic [FT_W-1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

endpackage

// File: rtl/flit_skid2.sv
// Two-entry in-order skid buffer. Absorbs the words already requested from
// the FIFO while downstream stalls. head always shows the oldest entry.
// A push and a pop in the same cycle leave the occupancy unchanged.
// The issuing side guarantees no push reaches a full buffer without a pop.
module flit_skid2 #(
    parameter int FLIT_W = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FLIT_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [FLIT_W-1:0] head
);

    logic [FLIT_W-1:0] entry0_reg;
    logic [FLIT_W-1:0] entry1_reg;
    logic [1:0]        occ_reg;
    logic              pop_eff;

    // A pop of an empty buffer is ignored.
    assign pop_eff = pop && (occ_reg != 2'd0);
    assign occ     = occ_reg;
    assign head    = entry0_reg;

    // Entry storage and occupancy; entry0 is always the oldest word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            entry0_reg <= '0;
            entry1_reg <= '0;
            occ_reg    <= 2'd0;
        end else begin
            case ({push, pop_eff})
                2'b10: begin
                    if (occ_reg == 2'd0) begin
                        entry0_reg <= push_data;
                    end else begin
                        entry1_reg <= push_data;
                    end
                    occ_reg <= occ_reg + 2'd1;
                end
                2'b01: begin
                    entry0_reg <= entry1_reg;
                    occ_reg    <= occ_reg - 2'd1;
                end
                2'b11: begin
                    if (occ_reg == 2'd2) begin
                        entry0_reg <= entry1_reg;
                        entry1_reg <= push_data;
                    end else begin
                        entry0_reg <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_flit_reader.sv
// Drain side of a router input-buffer FIFO. Issues read strobes, captures
// the registered FIFO data one cycle later into a 2-entry skid buffer,
// presents flits downstream with valid/ready, tracks packet framing from
// the flit-type field and counts delivered packets.
// Optional build macro FIFO_FLIT_READER_CHECK_EN adds a sticky frame_err
// output and restart handling for head/single flits inside a packet.
module fifo_flit_reader
    import noc_flit_pkg::*;
#(
    parameter int FLIT_W = FLIT_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drain_en,
    input  logic              fifo_empty,
    input  logic              fifo_wr,
    input  logic [FLIT_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  pkt_cnt,
`ifdef FIFO_FLIT_READER_CHECK_EN
    output logic              frame_err,
`endif
    output logic              busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_INPKT = 1'b1;

    logic [1:0]       occ;
    logic             inflight_reg;
    logic [1:0]       fill;
    logic             pop;
    flit_type_e       ftype;
    logic [0:0]       state_reg;
    logic [0:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
`ifdef FIFO_FLIT_READER_CHECK_EN
    logic             err_reg;
    logic             err_next;

    assign frame_err = err_reg;
`endif

    // Words already committed: those in the skid plus the one in flight.
    assign fill      = occ + {1'b0, inflight_reg};
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign busy      = (fill != 2'd0);
    assign pkt_cnt   = cnt_reg;
    assign ftype     = flit_type_e'(out_flit[FLIT_W-FT_MSB_OFS : FLIT_W-FT_LSB_OFS]);

    // Read issue: only when every committed word is guaranteed a skid slot.
    // The FIFO ignores reads during its own write cycles, so none is issued.
    always_comb begin
        fifo_rd = rst && drain_en && !fifo_empty && !fifo_wr &&
                  ((fill < 2'd2) || ((fill == 2'd2) && pop));
    end

    // In-flight flag: the FIFO data register holds our word next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= fifo_rd;
        end
    end

    flit_skid2 #(
        .FLIT_W (FLIT_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_reg),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .head      (out_flit)
    );

    // Framing decode for the flit accepted downstream this cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
`ifdef FIFO_FLIT_READER_CHECK_EN
        err_next   = err_reg;
`endif
        if (pop) begin
            case (ftype)
                FT_HEAD: begin
                    if (state_reg == ST_IDLE) begin
                        state_next = ST_INPKT;
                    end
`ifdef FIFO_FLIT_READER_CHECK_EN
                    else begin
                        // Head inside a packet restarts it; state stays INPKT.
                        err_next = 1'b1;
                    end
`endif
                end
                FT_SINGLE: begin
                    if (state_reg == ST_IDLE) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
`ifdef FIFO_FLIT_READER_CHECK_EN
                    else begin
                        // Single inside a packet abandons it and counts itself.
                        err_next   = 1'b1;
                        cnt_next   = cnt_reg + CNT_W'(1);
                        state_next = ST_IDLE;
                    end
`endif
                end
                FT_BODY: begin
`ifdef FIFO_FLIT_READER_CHECK_EN
                    if (state_reg == ST_IDLE) begin
                        err_next = 1'b1;
                    end
`endif
                end
                FT_TAIL: begin
                    if (state_reg == ST_INPKT) begin
                        state_next = ST_IDLE;
                        cnt_next   = cnt_reg + CNT_W'(1);
                    end
`ifdef FIFO_FLIT_READER_CHECK_EN
                    else begin
                        err_next = 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Framing state, packet counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
`ifdef FIFO_FLIT_READER_CHECK_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
`ifdef FIFO_FLIT_READER_CHECK_EN
            err_reg   <= err_next;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_flit_reader.sv
// Bench for fifo_flit_reader. A queue-based FIFO environment feeds the DUT;
// a transaction-level model (queue of fetched-but-undelivered flits plus a
// packet-rule table) predicts every output each cycle. The packet counter
// width is reduced here so the counter wrap is reached in a few hundred cycles.
module tb_fifo_flit_reader;
    import noc_flit_pkg::*;

    localparam int FW       = FLIT_W_DEF;
    localparam int TB_CNT_W = 8;

    logic                clk;
    logic                rst;
    logic                drain_en;
    logic                fifo_empty;
    logic                fifo_wr;
    logic [FW-1:0]       fifo_data;
    logic                fifo_rd;
    logic [FW-1:0]       out_flit;
    logic                out_valid;
    logic                out_ready;
    logic [TB_CNT_W-1:0] pkt_cnt;
    logic                busy;
`ifdef FIFO_FLIT_READER_CHECK_EN
    logic                frame_err;
`endif

    fifo_flit_reader #(
        .FLIT_W (FW),
        .CNT_W  (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .drain_en   (drain_en),
        .fifo_empty (fifo_empty),
        .fifo_wr    (fifo_wr),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pkt_cnt    (pkt_cnt),
`ifdef FIFO_FLIT_READER_CHECK_EN
        .frame_err  (frame_err),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment and model state.
    logic [FW-1:0] fq[$];     // words stored in the FIFO
    logic [FW-1:0] exp_q[$];  // words read from the FIFO, not yet delivered
    bit            infl_m;    // newest exp_q entry is still in the FIFO data register
    int            mcnt;      // packets completed since reset (unbounded)
    bit            min_pkt;
    bit            merr;
    bit            force_empty;
    logic [FW-1:0] wr_word;
    bit            check_en;
    bit            quiet;
    bit            last_rd;
    bit            last_ov;
    int            rd_cnt;
    int            ov_cnt;
    int            dlv_cnt;
    int            cyc_no;
    int            total;
    int            bad;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int id);
        return {t, 38'(id)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc_no);
        end
    endtask

    // Packet rules applied to one delivered flit.
    task automatic model_frame(input logic [FW-1:0] f);
        logic [1:0] t;
        t = f[FW-1:FW-2];
        case (t)
            2'b01: begin
                if (min_pkt) begin
`ifdef FIFO_FLIT_READER_CHECK_EN
                    merr = 1'b1;
`endif
                end
                min_pkt = 1'b1;
            end
            2'b11: begin
                if (!min_pkt) begin
                    mcnt++;
                end else begin
`ifdef FIFO_FLIT_READER_CHECK_EN
                    merr    = 1'b1;
                    mcnt++;
                    min_pkt = 1'b0;
`endif
                end
            end
            2'b10: begin
                if (min_pkt) begin
                    mcnt++;
                    min_pkt = 1'b0;
                end else begin
`ifdef FIFO_FLIT_READER_CHECK_EN
                    merr = 1'b1;
`endif
                end
            end
            default: begin
                if (!min_pkt) begin
`ifdef FIFO_FLIT_READER_CHECK_EN
                    merr = 1'b1;
`endif
                end
            end
        endcase
    endtask

    // One clock cycle: observe and compare, advance model/FIFO, cross the edge.
    task automatic cyc();
        logic [FW-1:0] word;
        logic [FW-1:0] f;
        bit            got_rd;
        bit            hs_m;
        bit            exp_rd;
        int            occ_m;
        word = '0;
        fifo_empty = force_empty || (fq.size() == 0);
        #1;
        occ_m  = exp_q.size() - int'(infl_m);
        hs_m   = (occ_m > 0) && out_ready;
        exp_rd = rst && drain_en && !fifo_empty && !fifo_wr &&
                 ((exp_q.size() < 2) || ((exp_q.size() == 2) && hs_m));
        if (check_en) begin
            chk("pkt_cnt", 64'(pkt_cnt), 64'(mcnt % (1 << TB_CNT_W)));
            chk("busy", 64'(busy), 64'(exp_q.size() != 0));
            chk("out_valid", 64'(out_valid), 64'(occ_m > 0));
            chk("fifo_rd", 64'(fifo_rd), 64'(exp_rd));
            chk("skid_overflow", 64'(exp_q.size() > 2), 64'(0));
            if (occ_m > 0) chk("out_flit", 64'(out_flit), 64'(exp_q[0]));
`ifdef FIFO_FLIT_READER_CHECK_EN
            chk("frame_err", 64'(frame_err), 64'(merr));
`endif
        end
        last_rd = fifo_rd;
        last_ov = out_valid;
        if (fifo_rd) rd_cnt++;
        if (out_valid) ov_cnt++;
        got_rd = fifo_rd && rst && !fifo_wr;
        if (got_rd) begin
            if (fq.size() > 0) word = fq.pop_front();
            else word = mk(2'b00, 38'h3DEAD);
        end
        if (fifo_wr) fq.push_back(wr_word);
        if (!rst) begin
            exp_q.delete();
            mcnt    = 0;
            min_pkt = 1'b0;
            merr    = 1'b0;
        end else begin
            if (hs_m) begin
                f = exp_q.pop_front();
                model_frame(f);
                dlv_cnt++;
                if (!quiet) $display("deliver cycle=%0d flit=%h type=%b pkts=%0d",
                                     cyc_no, f, f[FW-1:FW-2], mcnt);
            end
            if (got_rd) exp_q.push_back(word);
        end
        @(posedge clk);
        #1;
        infl_m    = got_rd && rst;
        fifo_data = got_rd ? word : FW'({$urandom, $urandom});
        cyc_no++;
    endtask

    task automatic run_until_idle(input int maxc, input string nm);
        int n;
        n = 0;
        while (((fq.size() != 0) || (exp_q.size() != 0)) && (n < maxc)) begin
            cyc();
            n++;
        end
        chk({nm, "_timeout"}, 64'((fq.size() != 0) || (exp_q.size() != 0)), 64'(0));
    endtask

    initial begin
        bit [7:0] rd_hist;
        bit [7:0] ov_hist;
        rst = 1'b0; drain_en = 1'b0; out_ready = 1'b0; fifo_wr = 1'b0;
        fifo_data = '0; fifo_empty = 1'b1; force_empty = 1'b0; wr_word = '0;
        check_en = 1'b0; quiet = 1'b0; infl_m = 1'b0;
        mcnt = 0; min_pkt = 1'b0; merr = 1'b0;
        total = 0; bad = 0; cyc_no = 0; rd_cnt = 0; ov_cnt = 0; dlv_cnt = 0;

        // Reset state.
        repeat (3) cyc();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_flit", 64'(out_flit), 64'(0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_fifo_rd", 64'(fifo_rd), 64'(0));
        check_en = 1'b1;

        // Pre-loaded head/body/tail at full rate.
        fq.push_back(mk(FT_HEAD, 1));
        fq.push_back(mk(FT_BODY, 2));
        fq.push_back(mk(FT_TAIL, 3));
        rst = 1'b1; drain_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            rd_hist[i] = last_rd;
            ov_hist[i] = last_ov;
        end
        chk("t1_rd_pattern", 64'(rd_hist), 64'(8'b0000_0111));
        chk("t1_valid_pattern", 64'(ov_hist), 64'(8'b0001_1100));
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'(1));

        // Five flits under backpressure: exactly two reads, then full-rate drain.
        out_ready = 1'b0;
        fq.push_back(mk(FT_HEAD, 10));
        for (int i = 11; i < 14; i++) fq.push_back(mk(FT_BODY, i));
        fq.push_back(mk(FT_TAIL, 14));
        rd_cnt = 0;
        repeat (6) cyc();
        chk("t2_stall_reads", 64'(rd_cnt), 64'(2));
        chk("t2_stall_valid", 64'(out_valid), 64'(1));
        chk("t2_stall_flit", 64'(out_flit), 64'(mk(FT_HEAD, 10)));
        out_ready = 1'b1;
        rd_cnt = 0; dlv_cnt = 0;
        repeat (5) cyc();
        chk("t2_drain_flits", 64'(dlv_cnt), 64'(5));
        chk("t2_drain_reads", 64'(rd_cnt), 64'(3));
        run_until_idle(10, "t2");
        chk("t2_pkt_cnt", 64'(pkt_cnt), 64'(2));

        // FIFO write strobe blocks reads for two cycles.
        fq.push_back(mk(FT_SINGLE, 20));
        fq.push_back(mk(FT_SINGLE, 21));
        dlv_cnt = 0;
        cyc();
        rd_cnt = 0;
        fifo_wr = 1'b1; wr_word = mk(FT_SINGLE, 22);
        cyc();
        wr_word = mk(FT_SINGLE, 23);
        cyc();
        fifo_wr = 1'b0;
        chk("t3_reads_during_wr", 64'(rd_cnt), 64'(0));
        cyc();
        chk("t3_read_resumes", 64'(last_rd), 64'(1));
        run_until_idle(20, "t3");
        chk("t3_delivered", 64'(dlv_cnt), 64'(4));
        chk("t3_pkt_cnt", 64'(pkt_cnt), 64'(6));

        // Reset one cycle after a read is accepted.
        fq.push_back(mk(FT_SINGLE, 30));
        cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1; drain_en = 1'b0;
        ov_cnt = 0;
        repeat (3) cyc();
        chk("t4_out_valid", 64'(out_valid), 64'(0));
        chk("t4_busy", 64'(busy), 64'(0));
        chk("t4_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("t4_never_valid", 64'(ov_cnt), 64'(0));

        // Counter wrap.
        drain_en = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 255; i++) fq.push_back(mk(FT_SINGLE, 100 + i));
        run_until_idle(400, "t5_fill");
        quiet = 1'b0;
        chk("t5_pkt_cnt_max", 64'(pkt_cnt), 64'(8'hFF));
        fq.push_back(mk(FT_SINGLE, 99));
        run_until_idle(10, "t5_wrap");
        chk("t5_pkt_cnt_wrap", 64'(pkt_cnt), 64'(0));

        // Framing errors: body in IDLE, then head inside a packet.
        fq.push_back(mk(FT_BODY, 40));
        fq.push_back(mk(FT_HEAD, 41));
        fq.push_back(mk(FT_TAIL, 42));
        run_until_idle(20, "t6a");
        chk("t6_pkt_cnt_a", 64'(pkt_cnt), 64'(1));
`ifdef FIFO_FLIT_READER_CHECK_EN
        chk("t6_err_set", 64'(frame_err), 64'(1));
`endif
        fq.push_back(mk(FT_HEAD, 43));
        fq.push_back(mk(FT_HEAD, 44));
        fq.push_back(mk(FT_TAIL, 45));
        run_until_idle(20, "t6b");
        chk("t6_pkt_cnt_b", 64'(pkt_cnt), 64'(2));
`ifdef FIFO_FLIT_READER_CHECK_EN
        chk("t6_err_sticky", 64'(frame_err), 64'(1));
`endif
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
`ifdef FIFO_FLIT_READER_CHECK_EN
        chk("t6_err_cleared", 64'(frame_err), 64'(0));
`endif
        chk("t6_pkt_cnt_rst", 64'(pkt_cnt), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_flit_reader.md
Name: fifo_flit_reader

Overview:
- Drain side of a router input-buffer FIFO (40-bit flits, 8 deep, registered read data).
- Issues read strobes, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents flits downstream with a valid/ready handshake.
- Tracks packet framing from the flit-type field and counts packets delivered to the crossbar/output stage.

Parameters:
- FLIT_W, 40, flit width; must match the FIFO data width.
- CNT_W, 16, width of the delivered-packet counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- drain_en  in  1  permits new FIFO reads; in-flight reads always complete
- fifo_empty  in  1  FIFO empty flag
- fifo_wr  in  1  FIFO write strobe; the FIFO ignores a read in any cycle its write strobe is high
- fifo_data  in  FLIT_W  FIFO registered read data
- fifo_rd  out  1  FIFO read strobe
- out_flit  out  FLIT_W  flit to downstream
- out_valid  out  1  out_flit valid
- out_ready  in  1  downstream accepts the flit when out_valid && out_ready
- pkt_cnt  out  CNT_W  packets delivered
- busy  out  1  skid occupancy != 0 or a read is in flight

Behaviour:
- Reset, when rst==0 at a clk edge:
  - out_valid=0, out_flit=0, pkt_cnt=0, skid occupancy=0, in-flight=0, framing state=IDLE.
  - fifo_rd is forced 0 whenever rst==0.
  - A read in flight at reset is discarded.
- fifo_rd is combinational. It is 1 iff all of the following hold:
  - rst==1, drain_en==1, fifo_empty==0, fifo_wr==0;
  - (occ + inflight) < 2, or (occ + inflight) == 2 with a pop this cycle (out_valid && out_ready).
- Accepted read: fifo_rd==1 at edge t sets inflight=1. At edge t+1, fifo_data is written into the skid buffer and inflight clears unless a new read was also accepted.
- fifo_data is sampled only in the cycle after an accepted read; at all other times it is don't-care.
- Latency: FIFO word to out_valid is 2 cycles from fifo_rd (strobe edge, capture edge).
- Sustained throughput is 1 flit/cycle while out_ready==1 and the FIFO holds data with no concurrent writes.
- Skid buffer: 2 entries, in-order.
  - out_flit/out_valid always show the head entry.
  - Capture and pop in the same cycle keep occ unchanged.
  - Occupancy never exceeds 2. Overflow is impossible by the issue rule; the bench asserts this.
- Backpressure: out_valid is held high and out_flit held stable until accepted.
- Flit type is out_flit[FLIT_W-1:FLIT_W-2]: 01 head, 00 body, 10 tail, 11 single.
- Framing state machine, updated on each accepted output flit:
  - IDLE + head -> INPKT.
  - IDLE + single -> IDLE, pkt_cnt+1.
  - INPKT + body -> INPKT.
  - INPKT + tail -> IDLE, pkt_cnt+1.
  - Other combinations: state unchanged, handled by the optional feature.
- pkt_cnt wraps modulo 2^CNT_W.
- drain_en falling mid-packet: no new reads; already-fetched flits still drain.
- fifo_empty or fifo_wr high for one cycle: no read that cycle, no bubble beyond that cycle.

Optional Feature:
- Macro: FIFO_FLIT_READER_CHECK_EN.
- Defined:
  - Adds output frame_err (1 bit, reset 0). It is sticky and set on an accepted body/tail in IDLE, or head/single in INPKT.
  - Head/single in INPKT restarts a packet: state=INPKT for head, IDLE for single with pkt_cnt+1.
  - Body/tail in IDLE is forwarded without a count.
- Not defined:
  - No frame_err port; illegal types are forwarded unchanged.
  - pkt_cnt counts only per the four legal transitions.

Decomposition:
- Package noc_flit_pkg: FLIT_W default; flit-type encodings (FT_HEAD, FT_BODY, FT_TAIL, FT_SINGLE); type-field MSB/LSB constants.
- Sub-module flit_skid2: 2-entry in-order buffer with push/pop/occ/head outputs, parameterised on FLIT_W.
- Issue logic, in-flight flag and framing state machine stay in the top module.

Test Plan:
- FIFO pre-loaded with 3 flits (01_x, 00_x, 10_x), out_ready=1, drain_en=1 -> fifo_rd high 3 consecutive cycles; out_valid on cycles 2..4; pkt_cnt=1 after the tail.
- 5 flits queued, out_ready=0 -> exactly 2 reads issued, occ=2, fifo_rd stays 0; out_ready=1 -> remaining 3 drained in order at 1/cycle.
- fifo_wr=1 for 2 cycles while fifo_empty=0 -> fifo_rd=0 during those cycles; read resumes the next cycle; no duplicate or lost flit.
- rst=0 asserted one cycle after a read is accepted -> out_valid=0, pkt_cnt=0, busy=0; the in-flight word never appears.
- pkt_cnt=16'hFFFF, then a single flit (11_x) -> pkt_cnt=0.
- With FIFO_FLIT_READER_CHECK_EN: body flit in IDLE -> frame_err=1 and stays 1 through later legal packets until reset.
